arb_mux: RTL and testbench
==========================

Name: arb_mux

Overview:
- N-channel arbitrated multiplexer; generalises the combinational 2/4-way muxes to a parametrised channel count.
- Adds valid/ready handshakes, round-robin or fixed-priority arbitration, multi-beat grant locking and a registered output stage.
- Used wherever several requesters (CPU, DMA, video fetch) share one downstream bus or FIFO port in the Z80 system.

Parameters:
- WIDTH, 8, data width per channel.
- CHANNELS, 4, number of input channels; legal range 2..16.
- CHAN_W, 2, width of channel index; CHANNELS <= 2**CHAN_W is required.
- FIXED_PRI, 0, 0 = round-robin arbitration; 1 = fixed priority with the lowest index winning.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  CHANNELS  per-channel request/valid.
- in_last  input  CHANNELS  per-channel last-beat flag; sampled only on a transfer.
- in_data  input  CHANNELS*WIDTH  packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  CHANNELS  per-channel ready; at most one bit set (one-hot or zero).
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  registered data.
- out_chan  output  CHAN_W  index of the source channel for out_data.
- out_last  output  1  registered copy of in_last for the beat.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values (applied on the clk edge with rst=1):
  - out_valid=0, out_data=0, out_chan=0, out_last=0.
  - lock=0, lock_chan=0.
  - Round-robin pointer ptr=0.
  - in_ready is 0 while rst is high.
- Load enable: load_en = !out_valid || out_ready. This is combinational and gives full throughput of one beat per cycle.
- Selection (combinational), giving sel and any_req:
  - lock=1: sel=lock_chan; any_req=in_valid[lock_chan]. Other channels are ignored even when valid.
  - lock=0, FIXED_PRI=1: sel is the lowest i with in_valid[i]=1.
  - lock=0, FIXED_PRI=0: sel is the first i with in_valid[i]=1, searching ptr, ptr+1, … modulo CHANNELS (wrap from CHANNELS-1 to 0).
- in_ready[i] = load_en && any_req && (sel==i) && !rst. Zero combinational path from in_data to in_ready.
- Transfer: fire = in_valid[sel] && in_ready[sel]. On fire, next edge:
  - out_data <= in_data[sel]; out_chan <= sel; out_last <= in_last[sel]; out_valid <= 1.
- Output stage:
  - If out_valid && out_ready && !fire: out_valid <= 0.
  - out_data, out_chan and out_last hold while out_valid && !out_ready. No change is allowed while stalled.
- Lock state machine (UNLOCKED / LOCKED):
  - UNLOCKED, fire with in_last[sel]=0: go to LOCKED; lock_chan <= sel.
  - UNLOCKED, fire with in_last[sel]=1: stay UNLOCKED (single-beat packet).
  - LOCKED, fire with in_last[lock_chan]=1: go to UNLOCKED.
  - LOCKED with no fire: stay LOCKED, even if in_valid[lock_chan]=0. A bubble never releases the grant.
- Pointer update (round-robin only):
  - On a fire that ends a packet (in_last=1), ptr <= (sel==CHANNELS-1) ? 0 : sel+1.
  - Otherwise ptr holds. Fixed-priority mode ignores ptr.
- Boundary conditions:
  - No requests: in_ready=0, out_valid drains normally.
  - Simultaneous drain and load: a fire in the same cycle as out_ready=1 replaces the beat; out_valid stays 1.
  - Reset mid-packet: lock cleared and the output beat discarded. Upstream must restart the packet.
  - CHANNELS not a power of two: indices >= CHANNELS are never selected. Wrap goes to 0.
- Latency: one cycle from fire to out_valid.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0. After release, first grant is ch0.
- Round-robin fairness: FIXED_PRI=0, all channels valid, single-beat (in_last=1111), out_ready=1, data ch i = 8'hA0+i -> out_chan sequence 0,1,2,3,0; out_data A0,A1,A2,A3,A0; one beat per cycle.
- Fixed priority: FIXED_PRI=1, in_valid=4'b1010 continuously -> only ch1 is granted; ch3 in_ready stays 0.
- Lock: ch2 sends 3 beats (last on third) with a one-cycle in_valid bubble after beat 1, while ch0 is valid throughout -> out_chan=2,2,2 with no ch0 beat interleaved. Then ch0 is granted and ptr=3.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1, out_data=8'h5C -> out_data stays 5C and in_ready=0. Release gives the drain and the next load in the same cycle.
- Reset mid-packet: assert rst after beat 1 of a locked ch1 packet -> lock=0, out_valid=0. Next grant follows ptr=0 order.

Source files
------------

// File: rtl/arb_mux.sv
// N-channel arbitrated multiplexer with valid/ready handshakes, round-robin or fixed-priority
// arbitration, multi-beat grant locking and a registered output stage.
module arb_mux #(
  parameter int WIDTH     = 8,
  parameter int CHANNELS  = 4,
  parameter int CHAN_W    = 2,
  parameter int FIXED_PRI = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        in_valid,
  input  logic [CHANNELS-1:0]        in_last,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  output logic [CHANNELS-1:0]        in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [CHAN_W-1:0]          out_chan,
  output logic                       out_last
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  lock_state_t         state_reg;
  logic [CHAN_W-1:0]   lock_chan_reg;
  logic [CHAN_W-1:0]   ptr_reg;
  logic                out_valid_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic [CHAN_W-1:0]   out_chan_reg;
  logic                out_last_reg;

  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [CHANNELS-1:0] rr_hi_req;
  logic [CHAN_W-1:0]   low_sel;
  logic [CHAN_W-1:0]   rr_hi_sel;
  logic [CHAN_W-1:0]   rr_sel;
  logic [CHAN_W-1:0]   sel;
  logic                any_req;
  logic                load_en;
  logic                fire;
  logic                sel_last;

  // Unpack the channel data and mark requesters at or above the round-robin pointer.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
      assign rr_hi_req[gi] = in_valid[gi] && (CHAN_W'(gi) >= ptr_reg);
    end
  endgenerate

  always_comb begin
    low_sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) low_sel = CHAN_W'(i);
    end
  end

  always_comb begin
    rr_hi_sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rr_hi_req[i]) rr_hi_sel = CHAN_W'(i);
    end
  end

  // Nothing at or above the pointer means the search wraps to the lowest requester.
  assign rr_sel = (|rr_hi_req) ? rr_hi_sel : low_sel;

  always_comb begin
    if (state_reg == LOCKED) begin
      sel     = lock_chan_reg;
      any_req = in_valid[lock_chan_reg];
    end else begin
      sel     = (FIXED_PRI != 0) ? low_sel : rr_sel;
      any_req = |in_valid;
    end
  end

  assign load_en  = !out_valid_reg || out_ready;
  assign fire     = load_en && any_req && !rst;
  assign sel_last = in_last[sel];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready[gi] = fire && (sel == CHAN_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_last_reg  <= 1'b0;
      state_reg     <= UNLOCKED;
      lock_chan_reg <= '0;
      ptr_reg       <= '0;
    end else begin
      if (fire) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= chan_data[sel];
        out_chan_reg  <= sel;
        out_last_reg  <= sel_last;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end

      case (state_reg)
        UNLOCKED: begin
          if (fire && !sel_last) begin
            state_reg     <= LOCKED;
            lock_chan_reg <= sel;
          end
        end
        LOCKED: begin
          // A bubble on the locked channel keeps the grant; only its last beat releases it.
          if (fire && sel_last) state_reg <= UNLOCKED;
        end
        default: state_reg <= UNLOCKED;
      endcase

      if (fire && sel_last && (FIXED_PRI == 0)) begin
        ptr_reg <= (sel == CHAN_W'(CHANNELS - 1)) ? '0 : sel + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: a round-robin and a fixed-priority instance share random stimulus and are
// compared every cycle against a packet-level model, plus directed literal checks.
module tb_arb_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  logic [N*W-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic [N-1:0] rr_in_ready, fp_in_ready;
  logic         rr_out_valid, fp_out_valid;
  logic [W-1:0] rr_out_data, fp_out_data;
  logic [1:0]   rr_out_chan, fp_out_chan;
  logic         rr_out_last, fp_out_last;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  arb_mux #(.WIDTH(W), .CHANNELS(N), .CHAN_W(2), .FIXED_PRI(0)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_ready(out_ready),
    .out_data(rr_out_data), .out_chan(rr_out_chan), .out_last(rr_out_last)
  );

  arb_mux #(.WIDTH(W), .CHANNELS(N), .CHAN_W(2), .FIXED_PRI(1)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_ready(out_ready),
    .out_data(fp_out_data), .out_chan(fp_out_chan), .out_last(fp_out_last)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Model state per instance: index 0 = round-robin, 1 = fixed priority.
  int m_ov[2], m_od[2], m_oc[2], m_ol[2], m_lock[2], m_lc[2], m_ptr[2];

  function automatic int pick(input int k, output bit any);
    int c;
    any = 1'b0;
    if (m_lock[k] != 0) begin
      any = in_valid[m_lc[k]];
      return m_lc[k];
    end
    for (int j = 0; j < N; j++) begin
      c = (k == 1) ? j : (m_ptr[k] + j) % N;
      if (in_valid[c]) begin
        any = 1'b1;
        return c;
      end
    end
    return 0;
  endfunction

  always @(negedge clk) begin
    int  sel;
    bit  any;
    bit  fire;
    int  exp_rdy;
    int  g_rdy, g_ov, g_od, g_oc, g_ol;
    string tag;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        tag = (k == 0) ? "rr" : "fp";
        sel = pick(k, any);
        fire = ((m_ov[k] == 0) || out_ready) && any && !rst;
        exp_rdy = fire ? (1 << sel) : 0;
        if (k == 0) begin
          g_rdy = rr_in_ready; g_ov = rr_out_valid; g_od = rr_out_data;
          g_oc = rr_out_chan;  g_ol = rr_out_last;
        end else begin
          g_rdy = fp_in_ready; g_ov = fp_out_valid; g_od = fp_out_data;
          g_oc = fp_out_chan;  g_ol = fp_out_last;
        end
        chk({tag, " in_ready"}, g_rdy, exp_rdy);
        chk({tag, " out_valid"}, g_ov, m_ov[k]);
        chk({tag, " out_data"}, g_od, m_od[k]);
        chk({tag, " out_chan"}, g_oc, m_oc[k]);
        chk({tag, " out_last"}, g_ol, m_ol[k]);
        if (g_ov != 0 && out_ready && !rst)
          $display("beat %s ch=%0d data=%02h last=%0d", tag, g_oc, g_od, g_ol);
        if (rst) begin
          m_ov[k] = 0; m_od[k] = 0; m_oc[k] = 0; m_ol[k] = 0;
          m_lock[k] = 0; m_lc[k] = 0; m_ptr[k] = 0;
        end else if (fire) begin
          m_ov[k] = 1;
          m_od[k] = in_data[sel*W +: W];
          m_oc[k] = sel;
          m_ol[k] = in_last[sel];
          if (in_last[sel]) begin
            m_lock[k] = 0;
            m_ptr[k]  = (sel + 1) % N;
          end else begin
            m_lock[k] = 1;
            m_lc[k]   = sel;
          end
        end else if (out_ready) begin
          m_ov[k] = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    in_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset with all channels requesting, then round-robin fairness.
    rst = 1'b1;
    in_valid = 4'b1111;
    in_last = 4'b1111;
    in_data = 32'hA3A2A1A0;
    out_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    neg();
    chk("reset in_ready", rr_in_ready, 0);
    chk("reset out_valid", rr_out_valid, 0);
    chk("reset out_data", rr_out_data, 0);
    tick();
    rst = 1'b0;
    neg();
    chk("first grant", rr_in_ready, 4'b0001);
    for (int j = 0; j < 5; j++) begin
      tick();
      neg();
      chk("rr seq valid", rr_out_valid, 1);
      chk("rr seq chan", rr_out_chan, j % 4);
      chk("rr seq data", rr_out_data, 8'hA0 + (j % 4));
    end

    // Fixed priority with channels 1 and 3 requesting.
    tick();
    do_reset();
    in_valid = 4'b1010;
    in_last = 4'b1111;
    in_data = 32'h44332211;
    for (int j = 0; j < 6; j++) begin
      neg();
      chk("fp ready", fp_in_ready, 4'b0010);
      if (j > 0) begin
        chk("fp chan", fp_out_chan, 1);
        chk("fp data", fp_out_data, 8'h22);
      end
      tick();
    end

    // Lock: ch2 three-beat packet with a bubble while ch0 keeps requesting.
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0010; in_data = 32'h03021100;
    neg(); chk("lock pre ready", rr_in_ready, 4'b0010);
    tick();
    in_valid = 4'b0101; in_last = 4'b0000; in_data = 32'h03B01100;
    neg(); chk("lock b0 ready", rr_in_ready, 4'b0100);
    tick();
    in_valid = 4'b0001;
    neg(); chk("lock b0 chan", rr_out_chan, 2); chk("lock b0 data", rr_out_data, 8'hB0);
    chk("lock bubble ready", rr_in_ready, 0);
    tick();
    in_valid = 4'b0101; in_data = 32'h03B11100;
    neg(); chk("lock b1 ready", rr_in_ready, 4'b0100);
    tick();
    in_last = 4'b0100; in_data = 32'h03B21100;
    neg(); chk("lock b1 chan", rr_out_chan, 2); chk("lock b1 data", rr_out_data, 8'hB1);
    chk("lock b2 ready", rr_in_ready, 4'b0100);
    tick();
    in_valid = 4'b0011; in_last = 4'b1111;
    neg(); chk("lock b2 chan", rr_out_chan, 2); chk("lock b2 data", rr_out_data, 8'hB2);
    chk("lock b2 last", rr_out_last, 1);
    chk("after lock ready", rr_in_ready, 4'b0001);
    tick();

    // Backpressure for five cycles, then simultaneous drain and load.
    do_reset();
    in_valid = 4'b0001; in_last = 4'b1111; in_data = 32'h0000775C; out_ready = 1'b1;
    neg(); chk("bp load ready", rr_in_ready, 4'b0001);
    tick();
    out_ready = 1'b0; in_valid = 4'b0010;
    for (int j = 0; j < 5; j++) begin
      neg();
      chk("bp hold valid", rr_out_valid, 1);
      chk("bp hold data", rr_out_data, 8'h5C);
      chk("bp hold ready", rr_in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    neg(); chk("bp release ready", rr_in_ready, 4'b0010);
    tick();
    in_valid = 4'b0000;
    neg(); chk("bp next data", rr_out_data, 8'h77); chk("bp next chan", rr_out_chan, 1);
    chk("bp next valid", rr_out_valid, 1);
    tick();

    // Reset in the middle of a locked ch1 packet.
    do_reset();
    in_valid = 4'b0010; in_last = 4'b0000; in_data = 32'h0000C100;
    neg(); chk("mid load ready", rr_in_ready, 4'b0010);
    tick();
    rst = 1'b1; in_valid = 4'b0011;
    neg(); chk("mid rst ready", rr_in_ready, 0);
    tick();
    rst = 1'b0; in_last = 4'b1111;
    neg(); chk("mid out_valid", rr_out_valid, 0);
    chk("mid regrant", rr_in_ready, 4'b0001);
    tick();

    // Randomised traffic, model-checked every cycle.
    for (int j = 0; j < 600; j++) begin
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom & $urandom);
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 64) == 0;
      tick();
    end
    rst = 1'b0;
    neg();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
